spi_slave: RTL

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave_if.sv | 21 ++
 rtl/spi_slave.sv | 125 ++++++++++++
 2 files changed

// File: rtl/spi_slave_if.sv
// Serial and memory-side signals of the SPI slave bridge.
// The slave modport is the bridge side and the master modport is the bus and memory side.
interface spi_slave_if;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_slave.sv
// SPI slave: assembles 10-bit {cmd, payload} words for a memory and
// returns one 8-bit read byte per READ_DATA frame.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no frame; waits for SS_n low (first edge samples nothing)
// CHK_CMD   | samples bit 9 and selects the frame type
// WRITE     | bit 9 = 0; collects bits 8..0, then ignores MOSI
// READ_ADD  | bit 9 = 1, no address pending; collects bits 8..0
// READ_DATA | bit 9 = 1, address pending; collects word, then shifts tx byte
module spi_slave (
  input  logic         clk,
  input  logic         rst_n,
  spi_slave_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

  state_t      state;
  state_t      state_nxt;

  logic [8:0]  rx_shift;
  logic [3:0]  bit_cnt;
  logic        word_done;
  logic        gap;
  logic [7:0]  tx_shift;
  logic [2:0]  tx_cnt;
  logic        tx_active;
  logic        tx_done;
  logic        rd_addr_done;
  logic        miso;
  logic [9:0]  rx_data;
  logic        rx_valid;

  assign bus.MISO     = miso;
  assign bus.rx_data  = rx_data;
  assign bus.rx_valid = rx_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!bus.SS_n) state_nxt = CHK_CMD;
      CHK_CMD: begin
        if (bus.SS_n)       state_nxt = IDLE;
        else if (!bus.MOSI) state_nxt = WRITE;
        else if (rd_addr_done) state_nxt = READ_DATA;
        else                state_nxt = READ_ADD;
      end
      default: if (bus.SS_n) state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_shift     <= '0;
      bit_cnt      <= '0;
      word_done    <= 1'b0;
      gap          <= 1'b0;
      tx_shift     <= '0;
      tx_cnt       <= '0;
      tx_active    <= 1'b0;
      tx_done      <= 1'b0;
      rd_addr_done <= 1'b0;
      miso         <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state == IDLE || bus.SS_n) begin
        // frame end or abort: drop partial work, keep rx_data and rd_addr_done
        rx_shift  <= '0;
        bit_cnt   <= '0;
        word_done <= 1'b0;
        gap       <= 1'b0;
        tx_shift  <= '0;
        tx_cnt    <= '0;
        tx_active <= 1'b0;
        tx_done   <= 1'b0;
        miso      <= 1'b0;
      end else if (state == CHK_CMD) begin
        rx_shift <= {8'd0, bus.MOSI};
        bit_cnt  <= 4'd9;
      end else if (!word_done) begin
        rx_shift <= {rx_shift[7:0], bus.MOSI};
        if (bit_cnt == 4'd1) begin
          rx_data   <= {rx_shift, bus.MOSI};
          rx_valid  <= 1'b1;
          word_done <= 1'b1;
          gap       <= 1'b1;
          bit_cnt   <= '0;
          if (rx_shift[8:7] == 2'b10)      rd_addr_done <= 1'b1;
          else if (rx_shift[8:7] == 2'b11) rd_addr_done <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt - 4'd1;
        end
      end else if (state == READ_DATA) begin
        // gap skips the edge where tx_valid still reflects the previous request
        if (gap) begin
          gap <= 1'b0;
        end else if (tx_active) begin
          if (tx_cnt != 3'd0) begin
            miso     <= tx_shift[7];
            tx_shift <= {tx_shift[6:0], 1'b0};
            tx_cnt   <= tx_cnt - 3'd1;
          end else begin
            miso      <= 1'b0;
            tx_active <= 1'b0;
            tx_done   <= 1'b1;
          end
        end else if (!tx_done && bus.tx_valid) begin
          miso      <= bus.tx_data[7];
          tx_shift  <= {bus.tx_data[6:0], 1'b0};
          tx_cnt    <= 3'd7;
          tx_active <= 1'b1;
        end
      end
    end
  end

endmodule
